mem_arbiter: RTL and testbench

Sequencer that shares the single-ported unified memory between the fetch stage (IF) and the memory stage (MEM) of the 5-stage pipeline. It grants one requester at a time, tracks the outstanding transaction until the memory signals completion, and returns read data with a one-cycle done pulse. It drives per-stage stall lines that the pipeline ORs with the hazard-unit stalls. It discards in-flight fetches on a PC redirect and traps a hung memory with a watchdog.

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the single-ported unified memory between the fetch (IF) and memory (MEM)
// pipeline stages: one outstanding transaction, registered done pulses, flush discard, watchdog.
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, ERR} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t            state, state_n;
  logic              drop, drop_n;
  logic [7:0]        wait_cnt, wait_cnt_n;
  logic              wr_q, wr_n;
  logic              if_done_n, mem_done_n;
  logic [DATA_W-1:0] if_rdata_n, mem_rdata_n;
  logic              grant_mem, grant_if;

  // A requester whose done pulse is high is still holding its request, so it is skipped.
  assign grant_mem = rst_n && (state == IDLE) && mem_req && !mem_done;
  assign grant_if  = rst_n && (state == IDLE) && !grant_mem && if_req && !if_done && !flush;

  assign m_en    = grant_mem | grant_if;
  assign m_wr    = grant_mem & mem_wr;
  assign m_addr  = grant_mem ? mem_addr : (grant_if ? if_addr : '0);
  assign m_wdata = grant_mem ? mem_wdata : '0;

  assign stall_fetch = if_req & ~if_done;
  assign stall_mem   = mem_req & ~mem_done;
  assign busy        = (state != IDLE);
  assign err         = (state == ERR);

  always_comb begin
    state_n     = state;
    drop_n      = drop;
    wait_cnt_n  = wait_cnt;
    wr_n        = wr_q;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    if_rdata_n  = if_rdata;
    mem_rdata_n = mem_rdata;
    case (state)
      IDLE: begin
        if (grant_mem) begin
          state_n    = BUSY_MEM;
          wait_cnt_n = '0;
          wr_n       = mem_wr;
        end else if (grant_if) begin
          state_n    = BUSY_IF;
          wait_cnt_n = '0;
          drop_n     = 1'b0;
        end
      end
      BUSY_IF: begin
        if (m_done) begin
          state_n = IDLE;
          drop_n  = 1'b0;
          if (!drop && !flush) begin
            if_done_n  = 1'b1;
            if_rdata_n = m_rdata;
          end
        end else begin
          if (flush) drop_n = 1'b1;
          wait_cnt_n = wait_cnt + 8'd1;
          if (wait_cnt_n == WAIT_LIMIT) state_n = ERR;
        end
      end
      BUSY_MEM: begin
        if (m_done) begin
          state_n    = IDLE;
          mem_done_n = 1'b1;
          if (!wr_q) mem_rdata_n = m_rdata;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
          if (wait_cnt_n == WAIT_LIMIT) state_n = ERR;
        end
      end
      ERR: ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drop      <= 1'b0;
      wait_cnt  <= '0;
      wr_q      <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state     <= state_n;
      drop      <= drop_n;
      wait_cnt  <= wait_cnt_n;
      wr_q      <= wr_n;
      if_done   <= if_done_n;
      mem_done  <= mem_done_n;
      if_rdata  <= if_rdata_n;
      mem_rdata <= mem_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency-programmable memory model answers m_en,
// expected done data is queued per stage when a request is raised and popped on each done pulse.
module tb_mem_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              mem_req = 1'b0;
  logic              mem_wr = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              flush = 1'b0;
  logic              m_en, m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_done = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              if_done, mem_done;
  logic [DATA_W-1:0] if_rdata, mem_rdata;
  logic              stall_fetch, stall_mem, busy, err;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .flush(flush),
    .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_rdata(m_rdata),
    .if_done(if_done), .if_rdata(if_rdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] if_q[$];
  logic [DATA_W-1:0] mem_q[$];
  logic if_pend = 1'b0, mem_pend = 1'b0, hang = 1'b0;
  logic saw_if_done = 1'b0, saw_mem_done = 1'b0;
  int mem_lat = 1, mem_cnt = 0, m_en_count = 0;
  logic [DATA_W-1:0] mem_resp = '0;
  logic [DATA_W-1:0] exp_if_rdata = '0, exp_mem_rdata = '0, model_mem_last = '0;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [DATA_W-1:0] memModel(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hE5A5;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit is_mem, input bit wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input bit expect_done);
    if (is_mem) begin
      mem_req = 1'b1; mem_wr = wr; mem_addr = addr; mem_wdata = wdata; mem_pend = 1'b1;
      if (expect_done) begin
        if (!wr) model_mem_last = memModel(addr);
        mem_q.push_back(model_mem_last);
      end
    end else begin
      if_req = 1'b1; if_addr = addr; if_pend = 1'b1;
      if (expect_done) if_q.push_back(memModel(addr));
    end
  endtask

  // Sample the current cycle, check grant fields and pop the scoreboard on done pulses.
  task automatic observe();
    #1;
    if (m_en === 1'b1) begin
      m_en_count++;
      mem_cnt  = mem_lat;
      mem_resp = memModel(m_addr);
      if (mem_pend) begin
        checkOutput("grant_mem_wr", 32'(m_wr), 32'(mem_wr));
        checkOutput("grant_mem_addr", 32'(m_addr), 32'(mem_addr));
        checkOutput("grant_mem_wdata", 32'(m_wdata), 32'(mem_wdata));
        mem_pend = 1'b0;
      end else if (if_pend) begin
        checkOutput("grant_if_wr", 32'(m_wr), 32'd0);
        checkOutput("grant_if_addr", 32'(m_addr), 32'(if_addr));
        checkOutput("grant_if_wdata", 32'(m_wdata), 32'd0);
        if_pend = 1'b0;
      end else begin
        checkOutput("spurious_m_en", 32'd1, 32'd0);
      end
    end
    saw_if_done  = (if_done === 1'b1);
    saw_mem_done = (mem_done === 1'b1);
    if (saw_if_done) begin
      if (if_q.size() == 0) checkOutput("unexpected_if_done", 32'd1, 32'd0);
      else begin
        exp_if_rdata = if_q.pop_front();
        checkOutput("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
      end
    end
    if (saw_mem_done) begin
      if (mem_q.size() == 0) checkOutput("unexpected_mem_done", 32'd1, 32'd0);
      else begin
        exp_mem_rdata = mem_q.pop_front();
        checkOutput("mem_rdata", 32'(mem_rdata), 32'(exp_mem_rdata));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    flush  = 1'b0;
    m_done = 1'b0;
    m_rdata = 16'h0BAD;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0 && !hang) begin
        m_done  = 1'b1;
        m_rdata = mem_resp;
      end
    end
    if (saw_if_done) if_req = 1'b0;
    if (saw_mem_done) mem_req = 1'b0;
    saw_if_done  = 1'b0;
    saw_mem_done = 1'b0;
  endtask

  task automatic runCycle();
    observe();
    advance();
  endtask

  task automatic waitIdle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < budget; n++) begin
      idle = !if_req && !mem_req && (if_q.size() == 0) && (mem_q.size() == 0);
      if (idle) break;
      runCycle();
    end
    idle = !if_req && !mem_req && (if_q.size() == 0) && (mem_q.size() == 0);
    checkOutput("drain_within_budget", 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base;
    #2 if_req = 1'b1;
    #1;
    checkOutput("rst_stall_fetch", 32'(stall_fetch), 32'd1);
    checkOutput("rst_m_en", 32'(m_en), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_dones", 32'({if_done, mem_done}), 32'd0);
    checkOutput("rst_rdata", 32'({if_rdata, mem_rdata}), 32'd0);
    if_req = 1'b0;
    #9 rst_n = 1'b1;
    advance();

    $display("[TB] single fetch, latency 2");
    mem_lat = 2;
    applyStimulus(0, 0, 16'h0040, '0, 1);
    observe();
    checkOutput("t1_grant_c0", 32'(m_en), 32'd1);
    checkOutput("t1_stall_c0", 32'(stall_fetch), 32'd1);
    advance();
    observe();
    checkOutput("t1_stall_c1", 32'(stall_fetch), 32'd1);
    checkOutput("t1_busy_c1", 32'(busy), 32'd1);
    checkOutput("t1_idle_bus_c1", 32'({m_en, m_wr, m_addr, m_wdata}), 32'd0);
    advance();
    observe();
    checkOutput("t1_stall_c2", 32'(stall_fetch), 32'd1);
    checkOutput("t1_done_c2", 32'(if_done), 32'd0);
    advance();
    observe();
    checkOutput("t1_done_c3", 32'(if_done), 32'd1);
    checkOutput("t1_rdata_c3", 32'(if_rdata), 32'h0000A5A5);
    checkOutput("t1_stall_c3", 32'(stall_fetch), 32'd0);
    advance();
    observe();
    checkOutput("t1_done_c4", 32'(if_done), 32'd0);
    checkOutput("t1_busy_c4", 32'(busy), 32'd0);
    advance();

    $display("[TB] simultaneous MEM read and IF fetch");
    mem_lat = 1;
    base = m_en_count;
    applyStimulus(1, 0, 16'h1000, '0, 1);
    applyStimulus(0, 0, 16'h0044, '0, 1);
    observe();
    checkOutput("t2_mem_first", 32'({m_en, m_addr}), 32'h00011000);
    advance();
    runCycle();
    observe();
    checkOutput("t2_if_grant_in_mem_done", 32'({mem_done, m_en}), 32'd3);
    checkOutput("t2_if_addr", 32'(m_addr), 32'h00000044);
    advance();
    waitIdle(20);
    checkOutput("t2_m_en_count", 32'(m_en_count - base), 32'd2);

    $display("[TB] MEM write");
    mem_lat = 2;
    applyStimulus(1, 1, 16'h2000, 16'hBEEF, 1);
    observe();
    checkOutput("t3_write_strobe", 32'({m_en, m_wr, m_wdata}), 32'h0003BEEF);
    advance();
    waitIdle(20);
    checkOutput("t3_mem_rdata_kept", 32'(mem_rdata), 32'(memModel(16'h1000)));

    $display("[TB] flush while fetch outstanding");
    mem_lat = 3;
    applyStimulus(0, 0, 16'h0100, '0, 0);
    observe();
    advance();
    flush = 1'b1;
    applyStimulus(0, 0, 16'h0200, '0, 1);
    observe();
    checkOutput("t4_no_grant_busy", 32'(m_en), 32'd0);
    advance();
    runCycle();
    observe();
    checkOutput("t4_no_grant_done", 32'(m_en), 32'd0);
    advance();
    observe();
    checkOutput("t4_discarded", 32'(if_done), 32'd0);
    checkOutput("t4_if_rdata_kept", 32'(if_rdata), 32'(memModel(16'h0044)));
    checkOutput("t4_regrant", 32'({m_en, m_addr}), 32'h00010200);
    advance();
    waitIdle(20);

    $display("[TB] flush coincident with m_done");
    mem_lat = 2;
    applyStimulus(0, 0, 16'h0300, '0, 0);
    observe();
    advance();
    runCycle();
    flush = 1'b1;
    applyStimulus(0, 0, 16'h0310, '0, 1);
    observe();
    checkOutput("t5_no_grant", 32'(m_en), 32'd0);
    advance();
    observe();
    checkOutput("t5_discarded", 32'(if_done), 32'd0);
    checkOutput("t5_if_rdata_kept", 32'(if_rdata), 32'(memModel(16'h0200)));
    checkOutput("t5_regrant", 32'({m_en, m_addr}), 32'h00010310);
    advance();
    waitIdle(20);

    $display("[TB] watchdog with memory withholding m_done");
    hang = 1'b1;
    applyStimulus(1, 0, 16'h3000, '0, 0);
    observe();
    checkOutput("t6_grant", 32'(m_en), 32'd1);
    advance();
    for (int i = 1; i <= MAX_WAIT; i++) begin
      observe();
      checkOutput("t6_err_low", 32'(err), 32'd0);
      checkOutput("t6_busy", 32'(busy), 32'd1);
      advance();
    end
    observe();
    checkOutput("t6_err_rise", 32'(err), 32'd1);
    base = m_en_count;
    applyStimulus(0, 0, 16'h0060, '0, 0);
    advance();
    repeat (4) runCycle();
    observe();
    checkOutput("t6_no_m_en", 32'(m_en_count - base), 32'd0);
    checkOutput("t6_stalls", 32'({stall_fetch, stall_mem}), 32'd3);
    checkOutput("t6_err_sticky", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_err", 32'(err), 32'd0);
    checkOutput("t6_rst_rdata", 32'({if_rdata, mem_rdata}), 32'd0);
    checkOutput("t6_rst_stalls", 32'({stall_fetch, stall_mem}), 32'd3);
    if_req = 1'b0; mem_req = 1'b0; if_pend = 1'b0; mem_pend = 1'b0;
    hang = 1'b0; mem_cnt = 0;
    if_q.delete(); mem_q.delete();
    exp_if_rdata = '0; model_mem_last = '0;
    #1 rst_n = 1'b1;
    advance();

    $display("[TB] fetch after reset");
    mem_lat = 1;
    applyStimulus(0, 0, 16'h0050, '0, 1);
    waitIdle(20);
    checkOutput("scoreboard_empty", 32'(if_q.size() + mem_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
